// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   AW_DEFAULT  : default RAM word-address width
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_D = 2'd1,
      WAIT_I = 2'd2,
      PROG   = 2'd3
   } arb_state_t;

   localparam int AW_DEFAULT = 12;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between a programmer port,
// a data port and an instruction-fetch port (priority in that order).
// Ports:
//   clk, Rst                          clock, synchronous active-high reset
//   d_rea, d_wea, d_be, d_addr, d_din data request; d_dout registered read result
//   i_en, i_addr                      fetch request;  i_dout registered instruction
//   p_ena, p_we, p_addr, p_din        programmer port (owns memory while p_ena=1)
//   ram_en, ram_we, ram_addr, ram_din RAM command; ram_dout valid one cycle later
//   mem_hold                          pipeline stall
//   stall_cnt                         saturating count of stall cycles
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          Rst,
   input  logic          d_rea,
   input  logic          d_wea,
   input  logic [3:0]    d_be,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_din,
   output logic [31:0]   d_dout,
   input  logic          i_en,
   input  logic [31:0]   i_addr,
   output logic [31:0]   i_dout,
   input  logic          p_ena,
   input  logic          p_we,
   input  logic [31:0]   p_addr,
   input  logic [31:0]   p_din,
   output logic          ram_en,
   output logic [3:0]    ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_din,
   input  logic [31:0]   ram_dout,
   output logic          mem_hold,
   output logic [31:0]   stall_cnt
);

   arb_state_t  state_q;
   arb_state_t  state_nxt;
   logic        d_rd_q;
   logic [31:0] d_dout_q;
   logic [31:0] i_dout_q;
   logic [31:0] stall_q;

   // Byte-lane and out-of-range address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{d_addr[31:AW+2], d_addr[1:0],
                               i_addr[31:AW+2], i_addr[1:0],
                               p_addr[31:AW+2], p_addr[1:0]};

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: begin
            if (p_ena)               state_nxt = PROG;
            else if (d_rea || d_wea) state_nxt = WAIT_D;
            else if (i_en)           state_nxt = WAIT_I;
         end
         WAIT_D: begin
            if (p_ena)     state_nxt = PROG;
            else if (i_en) state_nxt = WAIT_I;
            else           state_nxt = IDLE;
         end
         WAIT_I:  state_nxt = p_ena ? PROG : IDLE;
         PROG:    if (!p_ena) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: RAM command mux and stall. Everything is quiet while
   // Rst is high so a reset cycle never issues an access.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 4'b0000;
      ram_addr = '0;
      ram_din  = 32'd0;
      mem_hold = 1'b0;
      if (!Rst) begin
         unique case (state_q)
            IDLE: begin
               if (p_ena) begin
                  mem_hold = 1'b1;
               end else if (d_wea) begin
                  ram_en   = 1'b1;
                  ram_we   = d_be;
                  ram_addr = d_addr[AW+1:2];
                  ram_din  = d_din;
                  mem_hold = 1'b1;
               end else if (d_rea) begin
                  ram_en   = 1'b1;
                  ram_addr = d_addr[AW+1:2];
                  mem_hold = 1'b1;
               end else if (i_en) begin
                  ram_en   = 1'b1;
                  ram_addr = i_addr[AW+1:2];
                  mem_hold = 1'b1;
               end
            end
            WAIT_D: begin
               if (p_ena) begin
                  mem_hold = 1'b1;
               end else if (i_en) begin
                  // Chain the fetch right behind the data access.
                  ram_en   = 1'b1;
                  ram_addr = i_addr[AW+1:2];
                  mem_hold = 1'b1;
               end
            end
            WAIT_I: mem_hold = 1'b0;
            PROG: begin
               if (p_ena) begin
                  mem_hold = 1'b1;
                  if (p_we) begin
                     ram_en   = 1'b1;
                     ram_we   = 4'b1111;
                     ram_addr = p_addr[AW+1:2];
                     ram_din  = p_din;
                  end
               end
            end
            default: mem_hold = 1'b0;
         endcase
      end
   end

   // Result capture and stall counter
   always_ff @(posedge clk) begin
      if (Rst) begin
         d_rd_q   <= 1'b0;
         d_dout_q <= 32'd0;
         i_dout_q <= 32'd0;
         stall_q  <= 32'd0;
      end else begin
         if (mem_hold) stall_q <= sat_inc(stall_q);
         // Remember whether the data access being issued is a read, so a
         // write does not clobber d_dout when its WAIT_D cycle comes round.
         if (state_q == IDLE && !p_ena && (d_rea || d_wea)) d_rd_q <= !d_wea;
         if (state_q == WAIT_D && d_rd_q) d_dout_q <= ram_dout;
         if (state_q == WAIT_I)           i_dout_q <= ram_dout;
      end
   end

   assign d_dout    = d_dout_q;
   assign i_dout    = i_dout_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency RAM model.
module tb_mem_port_arbiter;

   localparam int AW = 12;

   logic          clk;
   logic          Rst;
   logic          d_rea, d_wea;
   logic [3:0]    d_be;
   logic [31:0]   d_addr, d_din, d_dout;
   logic          i_en;
   logic [31:0]   i_addr, i_dout;
   logic          p_ena, p_we;
   logic [31:0]   p_addr, p_din;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din, ram_dout;
   logic          mem_hold;
   logic [31:0]   stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:(1<<AW)-1];

   mem_port_arbiter #(.AW(AW)) dut (
      .clk(clk), .Rst(Rst),
      .d_rea(d_rea), .d_wea(d_wea), .d_be(d_be), .d_addr(d_addr),
      .d_din(d_din), .d_dout(d_dout),
      .i_en(i_en), .i_addr(i_addr), .i_dout(i_dout),
      .p_ena(p_ena), .p_we(p_we), .p_addr(p_addr), .p_din(p_din),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout),
      .mem_hold(mem_hold), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: contents preloaded while Rst is high, read data one cycle later.
   always @(posedge clk) begin
      if (Rst) begin
         mem[0] <= 32'h0000_0000;
         mem[1] <= 32'hA5A5_0001;
         mem[2] <= 32'hCAFE_BABE;
         mem[3] <= 32'h3333_4444;
         mem[4] <= 32'h0050_0093;
         mem[8] <= 32'hDEAD_BEEF;
      end else if (ram_en) begin
         ram_dout <= mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b1;
      d_rea = 1'b0; d_wea = 1'b0; d_be = 4'h0; d_addr = '0; d_din = '0;
      i_en = 1'b1;  i_addr = 32'h10;
      p_ena = 1'b0; p_we = 1'b0; p_addr = '0; p_din = '0;

      // Reset cycle with a pending fetch: nothing may be issued
      step(); #1;
      check_val("rst_hold", {31'd0, mem_hold}, 32'd0);
      check_val("rst_en",   {31'd0, ram_en},   32'd0);
      check_val("rst_we",   {28'd0, ram_we},   32'd0);
      step();
      check_val("rst_d_dout", d_dout,    32'd0);
      check_val("rst_i_dout", i_dout,    32'd0);
      check_val("rst_stall",  stall_cnt, 32'd0);
      Rst = 1'b0; i_en = 1'b0;
      #1;
      check_val("idle_hold", {31'd0, mem_hold}, 32'd0);
      check_val("idle_en",   {31'd0, ram_en},   32'd0);

      // Fetch only
      step();
      i_en = 1'b1; i_addr = 32'h10; #1;
      check_val("f_en",   {31'd0, ram_en},   32'd1);
      check_val("f_addr", {20'd0, ram_addr}, 32'd4);
      check_val("f_hold", {31'd0, mem_hold}, 32'd1);
      step(); #1;
      check_val("f_wait_hold",  {31'd0, mem_hold}, 32'd0);
      check_val("f_wait_idout", i_dout, 32'd0);
      step();
      i_en = 1'b0;
      check_val("f_idout", i_dout,    32'h0050_0093);
      check_val("f_stall", stall_cnt, 32'd1);

      // Read plus fetch
      d_rea = 1'b1; d_addr = 32'h20; i_en = 1'b1; i_addr = 32'h4; #1;
      check_val("rf_c1_addr", {20'd0, ram_addr}, 32'd8);
      check_val("rf_c1_we",   {28'd0, ram_we},   32'd0);
      check_val("rf_c1_hold", {31'd0, mem_hold}, 32'd1);
      step(); #1;
      check_val("rf_c2_addr", {20'd0, ram_addr}, 32'd1);
      check_val("rf_c2_en",   {31'd0, ram_en},   32'd1);
      check_val("rf_c2_hold", {31'd0, mem_hold}, 32'd1);
      step();
      d_rea = 1'b0; i_en = 1'b0;
      check_val("rf_ddout", d_dout, 32'hDEAD_BEEF);
      #1;
      check_val("rf_c3_hold", {31'd0, mem_hold}, 32'd0);
      step();
      check_val("rf_idout", i_dout,    32'hA5A5_0001);
      check_val("rf_stall", stall_cnt, 32'd3);   // 1 earlier + 2 here

      // Partial write
      d_wea = 1'b1; d_be = 4'b0011; d_addr = 32'h8; d_din = 32'h1234_5678; #1;
      check_val("w_we",   {28'd0, ram_we},   32'h3);
      check_val("w_addr", {20'd0, ram_addr}, 32'd2);
      check_val("w_din",  ram_din,           32'h1234_5678);
      step(); #1;
      check_val("w_wait_we",   {28'd0, ram_we},   32'd0);
      check_val("w_wait_hold", {31'd0, mem_hold}, 32'd0);
      step();
      d_wea = 1'b0; d_be = 4'h0;
      check_val("w_ddout", d_dout,    32'hDEAD_BEEF);
      check_val("w_mem",   mem[2],    32'hCAFE_5678);
      check_val("w_stall", stall_cnt, 32'd4);

      // Programmer burst
      p_ena = 1'b1; p_we = 1'b1; p_addr = 32'h0; p_din = 32'h1000_0001; #1;
      check_val("p_idle_en",   {31'd0, ram_en},   32'd0);
      check_val("p_idle_hold", {31'd0, mem_hold}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         p_addr = 32'(k * 4);
         p_din  = 32'h1000_0001 * 32'(k + 1);
         #1;
         check_val("p_we",   {28'd0, ram_we},   32'hF);
         check_val("p_addr", {20'd0, ram_addr}, 32'(k));
         check_val("p_hold", {31'd0, mem_hold}, 32'd1);
      end
      step();
      p_ena = 1'b0; p_we = 1'b0; #1;
      check_val("p_exit_hold", {31'd0, mem_hold}, 32'd0);
      check_val("p_exit_en",   {31'd0, ram_en},   32'd0);
      step(); #1;
      check_val("p_after_hold", {31'd0, mem_hold}, 32'd0);
      check_val("p_mem0", mem[0], 32'h1000_0001);
      check_val("p_mem1", mem[1], 32'h2000_0002);
      check_val("p_mem2", mem[2], 32'h3000_0003);
      check_val("p_stall", stall_cnt, 32'd8);

      // Priority: programmer arrives during WAIT_D with a fetch pending
      step();
      d_rea = 1'b1; d_addr = 32'hC; i_en = 1'b1; i_addr = 32'h10; #1;
      check_val("pr_addr", {20'd0, ram_addr}, 32'd3);
      step();
      p_ena = 1'b1; #1;
      check_val("pr_wd_en",   {31'd0, ram_en},   32'd0);
      check_val("pr_wd_hold", {31'd0, mem_hold}, 32'd1);
      step(); #1;
      check_val("pr_ddout",     d_dout,            32'h3333_4444);
      check_val("pr_prog_hold", {31'd0, mem_hold}, 32'd1);
      check_val("pr_prog_en",   {31'd0, ram_en},   32'd0);
      step();
      p_ena = 1'b0; d_rea = 1'b0; i_en = 1'b0; #1;
      check_val("pr_exit_hold", {31'd0, mem_hold}, 32'd0);
      step();
      check_val("pr_idout", i_dout,    32'hA5A5_0001);
      check_val("pr_stall", stall_cnt, 32'd11);

      // Reset while waiting on a fetch
      i_en = 1'b1; i_addr = 32'h10;
      step();
      Rst = 1'b1; #1;
      check_val("rw_hold", {31'd0, mem_hold}, 32'd0);
      check_val("rw_en",   {31'd0, ram_en},   32'd0);
      step();
      Rst = 1'b0; i_en = 1'b0;
      check_val("rw_idout", i_dout,    32'd0);
      check_val("rw_ddout", d_dout,    32'd0);
      check_val("rw_stall", stall_cnt, 32'd0);
      #1;
      check_val("rw_idle_hold", {31'd0, mem_hold}, 32'd0);
      step();
      check_val("rw_idout_late", i_dout, 32'd0);

      // Counter saturation
      force dut.stall_q = 32'hFFFF_FFFE;
      step();
      release dut.stall_q;
      check_val("sat_preload", stall_cnt, 32'hFFFF_FFFE);
      p_ena = 1'b1;
      step();
      check_val("sat_first", stall_cnt, 32'hFFFF_FFFF);
      step();
      step();
      check_val("sat_hold", stall_cnt, 32'hFFFF_FFFF);
      p_ena = 1'b0;
      step();
      step(); #1;
      check_val("sat_end_hold", {31'd0, mem_hold}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
